// File: rtl/fc_wr_ctrl.sv
// Fully-connected layer write controller: buffers one result vector and writes it out as bursts.
// Optional FC_WR_BRESP_WAIT_EN: wait for a matching write response after every burst.
module fc_wr_ctrl #(
    parameter int unsigned batch_size = 1,
    parameter int unsigned bias_size  = 1,
    parameter int unsigned burst_max  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [batch_size*bias_size*32-1:0]   FcNwc_result,
    input  logic                                 FcNwc_result_valid,
    output logic                                 NwcFc_result_ready,
    output logic                                 NwcNc_initAddrRq,
    input  logic [27:0]                          NcNwc_initAddr,
    input  logic                                 NcNwc_initAddrEn,
    output logic                                 NwcNc_wr_end,
    output logic                                 NwcBus_awvalid,
    output logic [3:0]                           NwcBus_awuserid,
    output logic [3:0]                           NwcBus_awlen,
    output logic [27:0]                          NwcBus_awaddr,
    input  logic                                 BusNwc_awready,
    output logic                                 NwcBus_wvalid,
    output logic [31:0]                          NwcBus_wdata,
    output logic                                 NwcBus_wlast,
    input  logic                                 BusNwc_wready,
    input  logic                                 BusNwc_bvalid,
    input  logic [3:0]                           BusNwc_bid,
    output logic                                 NwcBus_bready
);

    localparam int unsigned N     = batch_size * bias_size;
    localparam int unsigned CW    = $clog2(N + 1);
    localparam int unsigned Depth = 2 ** CW;
    localparam logic [3:0]  AWID  = 4'b1010;

`ifdef FC_WR_BRESP_WAIT_EN
    typedef enum logic [2:0] {StIdle, StAddrRq, StAw, StW, StB, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StAddrRq, StAw, StW, StDone} state_e;
`endif

    state_e        state_q, state_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    len_q, len_d;
    logic [27:0]   addr_q, addr_d;
    logic          load;
    logic [31:0]   buf_q [Depth];

    logic          ready_q, rq_q, wr_end_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [3:0]    awuserid_q;
    logic [31:0]   wdata_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        rem_d   = rem_q;
        beat_d  = beat_q;
        len_d   = len_q;
        addr_d  = addr_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (FcNwc_result_valid && ready_q) begin
                    load    = 1'b1;
                    k_d     = '0;
                    rem_d   = CW'(N);
                    state_d = StAddrRq;
                end
            end
            StAddrRq: begin
                if (NcNwc_initAddrEn) begin
                    addr_d  = NcNwc_initAddr;
                    state_d = StAw;
                end
            end
            StAw: begin
                if (BusNwc_awready) begin
                    beat_d  = '0;
                    state_d = StW;
                end
            end
            StW: begin
                if (BusNwc_wready) begin
                    k_d    = k_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == len_q) begin
                        addr_d = addr_q + 28'(len_q) + 28'd1;
`ifdef FC_WR_BRESP_WAIT_EN
                        state_d = StB;
`else
                        state_d = (rem_d == '0) ? StDone : StAw;
`endif
                    end
                end
            end
`ifdef FC_WR_BRESP_WAIT_EN
            StB: begin
                if (BusNwc_bvalid && (BusNwc_bid == AWID)) begin
                    state_d = (rem_q == '0) ? StDone : StAw;
                end
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Burst length is fixed on entry to AW so awlen stays stable while stalled.
        if ((state_d == StAw) && (state_q != StAw)) begin
            if (32'(rem_d) >= burst_max) begin
                len_d = 4'(burst_max - 1);
            end else begin
                len_d = 4'(rem_d - 1'b1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            rem_q   <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            rem_q   <= rem_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                buf_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= FcNwc_result[32*i +: 32];
            end
        end
    end

    // Outputs are registered from the next state so each appears in the cycle its state begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            rq_q       <= 1'b0;
            wr_end_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            awuserid_q <= '0;
            wvalid_q   <= 1'b0;
            wdata_q    <= '0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
        end else begin
            ready_q    <= (state_d == StIdle);
            rq_q       <= (state_d == StAddrRq);
            wr_end_q   <= (state_d == StDone);
            awvalid_q  <= (state_d == StAw);
            awuserid_q <= (state_d == StAw) ? AWID : 4'b0000;
            wvalid_q   <= (state_d == StW);
            wdata_q    <= (state_d == StW) ? buf_q[k_d] : 32'd0;
            wlast_q    <= (state_d == StW) && (beat_d == len_d);
`ifdef FC_WR_BRESP_WAIT_EN
            bready_q   <= (state_d == StB);
`else
            bready_q   <= 1'b1;
`endif
        end
    end

`ifndef FC_WR_BRESP_WAIT_EN
    logic unused_bresp;
    assign unused_bresp = ^{BusNwc_bvalid, BusNwc_bid};
`endif

    assign NwcFc_result_ready = ready_q;
    assign NwcNc_initAddrRq   = rq_q;
    assign NwcNc_wr_end       = wr_end_q;
    assign NwcBus_awvalid     = awvalid_q;
    assign NwcBus_awuserid    = awuserid_q;
    assign NwcBus_awlen       = len_q;
    assign NwcBus_awaddr      = addr_q;
    assign NwcBus_wvalid      = wvalid_q;
    assign NwcBus_wdata       = wdata_q;
    assign NwcBus_wlast       = wlast_q;
    assign NwcBus_bready      = bready_q;

endmodule

// File: tb/tb_fc_wr_ctrl.sv
// Bench for fc_wr_ctrl: N=20 instance with randomized bus stalls against a burst-list model,
// plus an N=1 instance driven by a hand-written sequence.
module tb_fc_wr_ctrl;

    localparam int unsigned N    = 20;
    localparam logic [3:0]  AWID = 4'b1010;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*32-1:0] result;
    logic            result_valid, result_ready, addr_rq, init_addr_en, wr_end;
    logic [27:0]     init_addr, awaddr;
    logic            awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [3:0]      awuserid, awlen, bid;
    logic [31:0]     wdata;

    logic [31:0] s1_result, s1_wdata;
    logic        s1_valid, s1_ready, s1_rq, s1_en, s1_wr_end;
    logic [27:0] s1_init_addr, s1_awaddr;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_wlast, s1_bvalid, s1_bready;
    logic [3:0]  s1_awuserid, s1_awlen, s1_bid;

    fc_wr_ctrl #(.batch_size(4), .bias_size(5), .burst_max(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .FcNwc_result(result), .FcNwc_result_valid(result_valid),
        .NwcFc_result_ready(result_ready), .NwcNc_initAddrRq(addr_rq),
        .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(init_addr_en), .NwcNc_wr_end(wr_end),
        .NwcBus_awvalid(awvalid), .NwcBus_awuserid(awuserid), .NwcBus_awlen(awlen),
        .NwcBus_awaddr(awaddr), .BusNwc_awready(awready),
        .NwcBus_wvalid(wvalid), .NwcBus_wdata(wdata), .NwcBus_wlast(wlast),
        .BusNwc_wready(wready), .BusNwc_bvalid(bvalid), .BusNwc_bid(bid), .NwcBus_bready(bready)
    );

    fc_wr_ctrl dut1 (
        .clk(clk), .rst_n(rst_n),
        .FcNwc_result(s1_result), .FcNwc_result_valid(s1_valid),
        .NwcFc_result_ready(s1_ready), .NwcNc_initAddrRq(s1_rq),
        .NcNwc_initAddr(s1_init_addr), .NcNwc_initAddrEn(s1_en), .NwcNc_wr_end(s1_wr_end),
        .NwcBus_awvalid(s1_awvalid), .NwcBus_awuserid(s1_awuserid), .NwcBus_awlen(s1_awlen),
        .NwcBus_awaddr(s1_awaddr), .BusNwc_awready(s1_awready),
        .NwcBus_wvalid(s1_wvalid), .NwcBus_wdata(s1_wdata), .NwcBus_wlast(s1_wlast),
        .BusNwc_wready(s1_wready), .BusNwc_bvalid(s1_bvalid), .BusNwc_bid(s1_bid),
        .NwcBus_bready(s1_bready)
    );

    typedef struct { logic [27:0] addr; logic [3:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;
    typedef struct {
        logic [27:0] base;
        int          stall;
        bit          noise;
        int          exp_nbursts;
        logic [27:0] exp_addr1;
        logic [3:0]  exp_len1;
    } vec_t;

    aw_t got_aw[$], exp_aw[$];
    w_t  got_w[$], exp_w[$];

    int          n_cmp = 0, n_fail = 0;
    logic [31:0] vec [N];
    logic [27:0] base;
    int          stall;
    bit          noise, send_req;
    int          wr_end_cnt;

    bit          p_aw_stall, p_w_stall, p_aw_hs, p_w_hs, p_wlast, p_accept, p_en_hs, p_wr_end;
    bit          b_outstanding;
    logic [27:0] p_awaddr;
    logic [3:0]  p_awlen;
    logic [31:0] p_wdata;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Sample outputs on the falling edge, then drive fresh inputs just after the rising edge.
    task automatic tick();
        logic will_accept;
        @(negedge clk);
        if (rst_n) begin
            if (p_aw_stall) begin
                chk("aw_hold_valid", 64'(awvalid), 64'd1);
                chk("aw_hold_addr_len", {awaddr, awlen}, {p_awaddr, p_awlen});
            end
            if (p_w_stall) chk("w_hold", {wvalid, wlast, wdata}, {1'b1, p_wlast, p_wdata});
            if (p_aw_hs) chk("aw_to_w", {awvalid, wvalid}, 64'b01);
            if (p_w_hs && !p_wlast) chk("w_no_bubble", 64'(wvalid), 64'd1);
            if (p_w_hs && p_wlast) begin
`ifdef FC_WR_BRESP_WAIT_EN
                chk("wlast_to_b", {bready, awvalid}, 64'b10);
`else
                chk("wlast_to_next", 64'(awvalid || wr_end), 64'd1);
`endif
            end
            if (p_accept) chk("accept_to_rq", 64'(addr_rq), 64'd1);
            if (p_en_hs) chk("en_to_aw", {addr_rq, awvalid}, 64'b01);
            if (p_wr_end) chk("wr_end_to_ready", {wr_end, result_ready}, 64'b01);
            if (bvalid && bready && bid == AWID) b_outstanding = 1'b0;
            if (awvalid && awready) begin
                got_aw.push_back('{awaddr, awlen});
                chk("awuserid", 64'(awuserid), 64'(AWID));
`ifdef FC_WR_BRESP_WAIT_EN
                chk("aw_after_bresp", 64'(b_outstanding), 64'd0);
`endif
            end
            if (wvalid && wready) begin
                got_w.push_back('{wdata, wlast});
                if (wlast) b_outstanding = 1'b1;
            end
            if (wr_end) wr_end_cnt++;
            p_aw_stall = awvalid && !awready;
            p_w_stall  = wvalid && !wready;
            p_aw_hs    = awvalid && awready;
            p_w_hs     = wvalid && wready;
            p_wlast    = wlast;
            p_accept   = result_valid && result_ready;
            p_en_hs    = addr_rq && init_addr_en;
            p_wr_end   = wr_end;
            p_awaddr   = awaddr;
            p_awlen    = awlen;
            p_wdata    = wdata;
        end else begin
            {p_aw_stall, p_w_stall, p_aw_hs, p_w_hs, p_wlast, p_accept, p_en_hs, p_wr_end} = '0;
            b_outstanding = 1'b0;
        end
        will_accept = rst_n && result_valid && result_ready;
        @(posedge clk);
        #1;
        if (will_accept) send_req = 1'b0;
        awready = int'($urandom_range(99)) >= stall;
        wready  = int'($urandom_range(99)) >= stall;
        if (addr_rq) begin
            init_addr_en = (stall == 0) || ($urandom_range(1) == 1);
            init_addr    = init_addr_en ? base : 28'($urandom);
        end else begin
            init_addr_en = noise && ($urandom_range(3) == 0);
            init_addr    = 28'($urandom);
        end
        if (send_req && result_ready) begin
            result_valid = 1'b1;
            for (int i = 0; i < N; i++) result[32*i +: 32] = vec[i];
        end else if (noise && !result_ready) begin
            result_valid = 1'b1;
            for (int i = 0; i < N; i++) result[32*i +: 32] = $urandom;
        end else begin
            result_valid = 1'b0;
        end
        bvalid = ($urandom_range(2) == 0);
        bid    = ($urandom_range(1) == 1) ? AWID : 4'b1001;
    endtask

    // Expected bus traffic: split N words into bursts of at most 16, addresses advance per word.
    task automatic build_model();
        int          rem, k, l;
        logic [27:0] a;
        exp_aw.delete();
        exp_w.delete();
        rem = N;
        k   = 0;
        a   = base;
        while (rem > 0) begin
            l = (rem > 16) ? 16 : rem;
            exp_aw.push_back('{a, 4'(l - 1)});
            for (int j = 0; j < l; j++) begin
                exp_w.push_back('{vec[k], j == l - 1});
                k++;
            end
            a   = a + 28'(l);
            rem = rem - l;
        end
    endtask

    task automatic start_txn(input logic [27:0] b, input int st, input bit nz);
        base  = b;
        stall = st;
        noise = nz;
        for (int i = 0; i < N; i++) vec[i] = $urandom;
        got_aw.delete();
        got_w.delete();
        wr_end_cnt = 0;
        build_model();
        send_req = 1'b1;
    endtask

    task automatic run_txn(input logic [27:0] b, input int st, input bit nz,
                           output int nb, output logic [27:0] a1, output logic [3:0] l1);
        int cyc;
        start_txn(b, st, nz);
        cyc = 0;
        while (wr_end_cnt == 0 && cyc < 3000) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        noise = 1'b0;
        chk("wr_end_count", 64'(wr_end_cnt), 64'd1);
        chk("aw_count", 64'(got_aw.size()), 64'(exp_aw.size()));
        chk("beat_count", 64'(got_w.size()), 64'(exp_w.size()));
        for (int i = 0; i < got_aw.size() && i < exp_aw.size(); i++)
            chk("aw_burst", {got_aw[i].addr, got_aw[i].len}, {exp_aw[i].addr, exp_aw[i].len});
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            chk("w_beat", {got_w[i].last, got_w[i].data}, {exp_w[i].last, exp_w[i].data});
        nb = got_aw.size();
        a1 = (got_aw.size() > 1) ? got_aw[1].addr : 28'd0;
        l1 = (got_aw.size() > 1) ? got_aw[1].len : 4'd0;
    endtask

    vec_t tbl [4];

    initial begin
        int          nb, cyc;
        logic [27:0] a1;
        logic [3:0]  l1;

        tbl[0] = '{28'h2000,    0,  1'b0, 2, 28'h2010,    4'd3};
        tbl[1] = '{28'hFFFFFF8, 30, 1'b1, 2, 28'h0000008, 4'd3};
        tbl[2] = '{28'h0000123, 40, 1'b1, 2, 28'h0000133, 4'd3};
        tbl[3] = '{28'h5555550, 70, 1'b0, 2, 28'h5555560, 4'd3};

        rst_n = 1'b0;
        result = '0; result_valid = 1'b0; init_addr = '0; init_addr_en = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0;
        s1_result = '0; s1_valid = 1'b0; s1_init_addr = '0; s1_en = 1'b0;
        s1_awready = 1'b1; s1_wready = 1'b1; s1_bvalid = 1'b1; s1_bid = AWID;
        base = '0; stall = 0; noise = 1'b0; send_req = 1'b0; wr_end_cnt = 0;
        b_outstanding = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {result_ready, addr_rq, wr_end, awvalid, wvalid, wlast, bready,
                           awuserid, awlen}, 64'd0);
        chk("reset_awaddr", 64'(awaddr), 64'd0);
        chk("reset_wdata", 64'(wdata), 64'd0);
        chk("reset_n1_ready", 64'(s1_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", {result_ready, s1_ready}, 64'b11);
`ifndef FC_WR_BRESP_WAIT_EN
        chk("bready_tied", 64'(bready), 64'd1);
`endif

        // Single-word vector on the N=1 instance.
        s1_result = 32'hDEADBEEF;
        s1_valid  = 1'b1;
        tick();
        s1_valid = 1'b0;
        chk("n1_rq", {s1_rq, s1_ready}, 64'b10);
        s1_en        = 1'b1;
        s1_init_addr = 28'h100;
        tick();
        s1_en = 1'b0;
        chk("n1_aw", {s1_rq, s1_awvalid, s1_awuserid, s1_awlen, s1_awaddr},
            {1'b0, 1'b1, AWID, 4'd0, 28'h100});
        tick();
        chk("n1_w", {s1_awvalid, s1_wvalid, s1_wlast, s1_wdata}, {1'b0, 1'b1, 1'b1, 32'hDEADBEEF});
        tick();
`ifdef FC_WR_BRESP_WAIT_EN
        tick();
`endif
        chk("n1_wr_end", {s1_wvalid, s1_wr_end, s1_ready}, 64'b010);
        tick();
        chk("n1_ready_back", {s1_wr_end, s1_ready}, 64'b01);

        for (int t = 0; t < 4; t++) begin
            run_txn(tbl[t].base, tbl[t].stall, tbl[t].noise, nb, a1, l1);
            chk("tbl_nbursts", 64'(nb), 64'(tbl[t].exp_nbursts));
            chk("tbl_burst1", {a1, l1}, {tbl[t].exp_addr1, tbl[t].exp_len1});
        end

        for (int t = 0; t < 5; t++) begin
            run_txn(28'($urandom), int'($urandom_range(60)), 1'($urandom_range(1)), nb, a1, l1);
        end

        // Reset while beat 7 is on the bus: abandon, then a fresh vector starts from word 0.
        start_txn(28'h3000, 0, 1'b0);
        cyc = 0;
        while (got_w.size() < 6 && cyc < 500) begin
            tick();
            cyc++;
        end
        chk("beat7_present", {wvalid, wdata}, {1'b1, vec[6]});
        rst_n = 1'b0;
        #1;
        chk("midburst_reset_ctrl", {result_ready, addr_rq, wr_end, awvalid, wvalid, wlast, bready,
                                    awuserid, awlen}, 64'd0);
        chk("midburst_reset_data", {awaddr, wdata}, 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("no_wr_end_after_reset", 64'(wr_end_cnt), 64'd0);
        run_txn(28'h0ABCDE0, 20, 1'b1, nb, a1, l1);
        chk("post_reset_burst1", {a1, l1}, {28'h0ABCDF0, 4'd3});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
